// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a word-wide distributed memory with async read and sync write.
// Sub-word stores are done as read-modify-write; loads are sign- or zero-extended per request.
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    output logic              Ready,
    input  logic              Wr,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W+1:0] ByteAddr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Done,
    output logic              Err,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    input  logic [31:0]       MemSPO,
    output logic [2:0]        DbgState
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RMW   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         mdata_q, mdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                misaligned;

    // Size=11 is treated as a word everywhere, so "word" is simply Size[1].
    assign misaligned = ((Size == 2'b01) && ByteAddr[0]) ||
                        (Size[1] && (ByteAddr[1:0] != 2'b00));

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        if (sz[1])
            return w;
        else if (sz == 2'b01)
            return uns ? {16'b0, h} : {{16{h[15]}}, h};
        else
            return uns ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b01) begin
            if (lane[1]) r[31:16] = d[15:0];
            else         r[15:0]  = d[15:0];
        end else begin
            r[{lane, 3'b000} +: 8] = d[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdata_d = mdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    size_d  = Size;
                    uns_d   = Unsigned;
                    lane_d  = ByteAddr[1:0];
                    addr_d  = ByteAddr[ADDR_W+1:2];
                    wdata_d = WData;
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else if (!Wr) begin
                        state_d = S_LOAD;
                    end else if (Size[1]) begin
                        state_d = S_WRITE;
                        mdata_d = WData;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = extend_load(MemSPO, size_q, lane_q, uns_q);
                state_d = S_DONE;
            end
            S_RMW: begin
                mdata_d = merge_store(MemSPO, size_q, lane_q, wdata_q);
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            mdata_q <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdata_q <= mdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write enable is gated by Rst so an abort in WRITE never reaches the memory.
    always_comb begin
        Ready    = (state_q == S_IDLE);
        Done     = (state_q == S_DONE) || (state_q == S_ERR);
        Err      = (state_q == S_ERR);
        MemWE    = (state_q == S_WRITE) && !Rst;
        MemAddr  = addr_q;
        MemData  = mdata_q;
        RData    = rdata_q;
        DbgState = state_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vectors, hand-written multi-cycle sequences and random ops
// checked against a byte-array reference of the memory.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req = 1'b0;
    logic        Ready;
    logic        Wr = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [7:0]  ByteAddr = 8'h00;
    logic [31:0] WData = 32'h0;
    logic [31:0] RData;
    logic        Done;
    logic        Err;
    logic        MemWE;
    logic [5:0]  MemAddr;
    logic [31:0] MemData;
    logic [31:0] MemSPO;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;

    logic [31:0] tb_mem [64] = '{default: 32'h0};
    logic [7:0]  ref_bytes [256];
    logic [31:0] model_rd;

    mem_access_unit #(.ADDR_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Ready(Ready), .Wr(Wr), .Size(Size),
        .Unsigned(Unsigned), .ByteAddr(ByteAddr), .WData(WData), .RData(RData),
        .Done(Done), .Err(Err), .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData),
        .MemSPO(MemSPO), .DbgState(dbg_state)
    );

    always #5 Clk = ~Clk;

    assign MemSPO = tb_mem[MemAddr];
    always @(posedge Clk) if (MemWE) tb_mem[MemAddr] <= MemData;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_err;
        int          exp_we;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] sz, input logic [7:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    endfunction

    function automatic int model_lat(input logic wr, input logic [1:0] sz, input logic [7:0] a);
        if (is_mis(sz, a)) return 1;
        if (!wr || sz[1]) return 2;
        return 3;
    endfunction

    task automatic model_apply(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [7:0] a, input logic [31:0] d);
        int nb;
        logic [31:0] v;
        if (is_mis(sz, a)) return;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (wr) begin
            for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            model_rd = v;
        end
    endtask

    task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] d,
                          output int lat, output logic err, output int we_cnt,
                          output logic [5:0] we_addr, output logic [31:0] we_data);
        int guard;
        lat = -1; err = 1'b0; we_cnt = 0; we_addr = 6'h0; we_data = 32'h0;
        guard = 0;
        @(negedge Clk);
        while (!Ready && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        Req = 1'b1; Wr = wr; Size = sz; Unsigned = uns; ByteAddr = a; WData = d;
        @(posedge Clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                Req = 1'b0; Wr = 1'($urandom); Size = 2'($urandom);
                ByteAddr = 8'($urandom); WData = $urandom;
            end
            if (MemWE) begin
                we_cnt++; we_addr = MemAddr; we_data = MemData;
            end
            if (Done) begin
                lat = c; err = Err;
                break;
            end
        end
    endtask

    initial begin
        int lat, we_cnt, rdy_c;
        logic err;
        logic [5:0] wa;
        logic [31:0] wd, exp_w;
        logic r_wr, r_uns;
        logic [1:0] r_sz;
        logic [7:0] r_a;
        logic [31:0] r_d;
        int mem_bad;

        foreach (ref_bytes[i]) ref_bytes[i] = 8'h00;
        model_rd = 32'h0;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 8'h04, 32'h11223344, 32'h00000000, 2, 1'b0, 1, 32'h11223344};
        tbl[1]  = '{1'b0, 2'b10, 1'b1, 8'h04, 32'h0,        32'h11223344, 2, 1'b0, 0, 32'h0};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 8'h05, 32'h000000AA, 32'h11223344, 3, 1'b0, 1, 32'h1122AA44};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 8'h04, 32'h0,        32'h1122AA44, 2, 1'b0, 0, 32'h0};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 8'h05, 32'h0,        32'hFFFFFFAA, 2, 1'b0, 0, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 8'h05, 32'h0,        32'h000000AA, 2, 1'b0, 0, 32'h0};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, 8'h06, 32'h0,        32'h00001122, 2, 1'b0, 0, 32'h0};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 8'h06, 32'h00008001, 32'h00001122, 3, 1'b0, 1, 32'h8001AA44};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 8'h06, 32'h0,        32'hFFFF8001, 2, 1'b0, 0, 32'h0};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 8'h03, 32'h00001234, 32'hFFFF8001, 1, 1'b1, 0, 32'h0};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 8'h06, 32'h0,        32'hFFFF8001, 1, 1'b1, 0, 32'h0};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 8'h04, 32'h0,        32'h8001AA44, 2, 1'b0, 0, 32'h0};
        tbl[12] = '{1'b0, 2'b11, 1'b1, 8'h04, 32'h0,        32'h8001AA44, 2, 1'b0, 0, 32'h0};
        tbl[13] = '{1'b0, 2'b11, 1'b0, 8'h05, 32'h0,        32'h8001AA44, 1, 1'b1, 0, 32'h0};
        tbl[14] = '{1'b0, 2'b00, 1'b0, 8'h07, 32'h0,        32'hFFFFFF80, 2, 1'b0, 0, 32'h0};
        tbl[15] = '{1'b0, 2'b01, 1'b1, 8'h04, 32'h0,        32'h0000AA44, 2, 1'b0, 0, 32'h0};
        tbl[16] = '{1'b1, 2'b11, 1'b0, 8'h0C, 32'h0BADF00D, 32'h0000AA44, 2, 1'b0, 1, 32'h0BADF00D};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_rdata", RData, 32'h0);
        check("rst_memwe", 32'(MemWE), 32'd0);
        check("rst_memaddr", 32'(MemAddr), 32'h0);
        check("rst_memdata", MemData, 32'h0);
        Rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                   lat, err, we_cnt, wa, wd);
            model_apply(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_rdata", i), RData, tbl[i].exp_rdata);
            check($sformatf("vec%0d_we_cnt", i), 32'(we_cnt), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we == 1) begin
                check($sformatf("vec%0d_we_addr", i), 32'(wa), 32'(tbl[i].addr[7:2]));
                check($sformatf("vec%0d_we_data", i), wd, tbl[i].exp_mdata);
            end
        end

        // Reset during the WRITE cycle of a word store must suppress the write entirely.
        run_op(1'b1, 2'b10, 1'b0, 8'h08, 32'h55667788, lat, err, we_cnt, wa, wd);
        model_apply(1'b1, 2'b10, 1'b0, 8'h08, 32'h55667788);
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Size = 2'b10; Unsigned = 1'b0; ByteAddr = 8'h08; WData = 32'hDEADBEEF;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        Rst = 1'b1;
        #1;
        check("abort_memwe_gated", 32'(MemWE), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_err", 32'(Err), 32'd0);
        check("abort_rdata", RData, 32'h0);
        check("abort_memwe", 32'(MemWE), 32'd0);
        check("abort_memaddr", 32'(MemAddr), 32'h0);
        check("abort_memdata", MemData, 32'h0);
        check("abort_mem_word2", tb_mem[2], 32'h55667788);
        Rst = 1'b0;
        model_rd = 32'h0;
        run_op(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, lat, err, we_cnt, wa, wd);
        model_apply(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
        check("abort_reload", RData, 32'h55667788);

        // Req held high with changing fields while busy: only the accepted store runs.
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Size = 2'b10; Unsigned = 1'b0; ByteAddr = 8'h10; WData = 32'hCAFEF00D;
        @(posedge Clk);
        we_cnt = 0; rdy_c = -1; wa = 6'h0; wd = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (MemWE) begin
                we_cnt++; wa = MemAddr; wd = MemData;
            end
            if (Ready) begin
                rdy_c = c;
                Wr = 1'b0; Size = 2'b10; Unsigned = 1'b0; ByteAddr = 8'h10;
                break;
            end
            Wr = 1'b1; Size = 2'($urandom); ByteAddr = 8'($urandom); WData = $urandom;
        end
        check("hold_ready_cycle", 32'(rdy_c), 32'd3);
        check("hold_we_cnt", 32'(we_cnt), 32'd1);
        check("hold_we_addr", 32'(wa), 32'd4);
        check("hold_we_data", wd, 32'hCAFEF00D);
        model_apply(1'b1, 2'b10, 1'b0, 8'h10, 32'hCAFEF00D);
        @(posedge Clk);
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (c == 1) Req = 1'b0;
            if (Done) begin
                lat = c;
                break;
            end
        end
        model_apply(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        check("hold_load_lat", 32'(lat), 32'd2);
        check("hold_load_rdata", RData, 32'hCAFEF00D);

        for (int i = 0; i < 60; i++) begin
            r_wr = 1'($urandom); r_sz = 2'($urandom); r_uns = 1'($urandom);
            r_a = 8'($urandom_range(0, 255)); r_d = $urandom;
            run_op(r_wr, r_sz, r_uns, r_a, r_d, lat, err, we_cnt, wa, wd);
            model_apply(r_wr, r_sz, r_uns, r_a, r_d);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(r_wr, r_sz, r_a)));
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(is_mis(r_sz, r_a)));
            check($sformatf("rnd%0d_rdata", i), RData, model_rd);
            check($sformatf("rnd%0d_we_cnt", i), 32'(we_cnt),
                  32'((r_wr && !is_mis(r_sz, r_a)) ? 1 : 0));
        end

        mem_bad = 0;
        for (int w = 0; w < 64; w++) begin
            exp_w = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
            if (tb_mem[w] !== exp_w) mem_bad++;
        end
        check("final_mem_words_wrong", 32'(mem_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
